hc_buffer_regfile: RTL and testbench
====================================

# hc_buffer_regfile

Parametrised HardCloud MMIO register file holding the DSM base, control register and a table of NUM_BUFFERS address/size buffer descriptors, with a control state machine that gates the compute engine. Sits between the CCI-P MMIO decode and the AFU datapath (read/write request FSMs). It adds strict bounds checking, descriptor-valid tracking, MMIO readback and a write-error counter. Out-of-range buffer writes never alias onto another descriptor.

## Interface
- NUM_BUFFERS, 2: number of descriptors, 1..16.
- DSM_ADDR, 16'h110: byte address of the DSM base register.
- CONTROL_ADDR, 16'h118: byte address of the control register.
- STATUS_ADDR, 16'h108: byte address of the read-only status register.
- BUF_BASE_ADDR, 16'h120: byte address of descriptor 0.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mmio_wr_valid  in  1  MMIO write strobe.
- mmio_rd_valid  in  1  MMIO read strobe; never asserted together with mmio_wr_valid.
- mmio_addr  in  16  dword address (byte address >> 2).
- mmio_tid  in  9  read transaction id.
- mmio_wdata  in  64  write data.
- mmio_rsp_valid  out  1  read response strobe.
- mmio_rsp_tid  out  9  echoed tid.
- mmio_rsp_data  out  64  read data.
- engine_done  in  1  one-cycle completion pulse from the datapath.
- dsm_base  out  64  DSM base address.
- buf_addr  out  64*NUM_BUFFERS  descriptor addresses; descriptor i in [64i+63:64i].
- buf_size  out  32*NUM_BUFFERS  descriptor sizes.
- buf_valid  out  NUM_BUFFERS  both address and size have been written.
- afu_reset  out  1  datapath reset.
- afu_running  out  1  state is RUN.
- start_pulse  out  1  one-cycle pulse on entry to RUN.
- err_cnt  out  8  saturating MMIO error count.

## Operation
- Decode only applies when mmio_addr < 16'h100. Other addresses are ignored, with no error.
- Descriptor i address register: dword (BUF_BASE_ADDR>>2)+4i. Size register: (BUF_BASE_ADDR>>2)+4i+2. Size takes wdata[31:0].
- A hit requires all of the following: offset = mmio_addr-(BUF_BASE_ADDR>>2) ≥ 0, offset[0]==0, and offset>>2 < NUM_BUFFERS. Index = offset>>2.
- Any write with mmio_addr ≥ BUF_BASE_ADDR>>2 and < 16'h100 that is not a hit increments err_cnt (saturates at 255) and changes no register.
- Writes to DSM_ADDR load dsm_base.
- buf_valid[i] sets when both halves of descriptor i have been written since the last ASSERT_RST.
- Control FSM states: RST, IDLE, RUN. Writes to CONTROL_ADDR use wdata[31:0]:
  - 0x0 (ASSERT_RST): any state -> RST. Clears buf_valid. Descriptor contents are kept.
  - 0x1 (DEASSERT_RST): RST -> IDLE.
  - 0x3 (START): IDLE -> RUN if &buf_valid. Otherwise stay in IDLE and increment err_cnt.
  - 0x7 (STOP): RUN -> IDLE.
  - Any other value, or a legal command in the wrong state: ignored, no error.
- engine_done in RUN -> IDLE. If engine_done coincides with STOP, the result is IDLE. engine_done outside RUN is ignored.
- afu_reset = (state==RST).
- Readback:
  - Descriptor, DSM and control addresses return the stored value. Control reads as {62'b0, state}, with RST=0, IDLE=1, RUN=2.
  - STATUS_ADDR returns {47'b0, &buf_valid, err_cnt, 6'b0, state}.
  - Unmapped addresses return 0.

## Timing
- Reset values:
  - state RST, afu_reset 1.
  - All descriptors, dsm_base, buf_valid, err_cnt, mmio_rsp_*, start_pulse, afu_running: 0.
- A write is visible on outputs the cycle after mmio_wr_valid.
- A read response arrives exactly 1 cycle after mmio_rd_valid. It carries register state from before any write in that same cycle. Back-to-back reads are supported every cycle.
- start_pulse is high in the first RUN cycle only.
- Reset asserted mid-RUN: all outputs return to reset values asynchronously. A pending read response is dropped.

## Configuration
- HC_BUF_LOCK_EN defined:
  - Descriptor writes while in RUN are rejected and each one increments err_cnt.
  - DSM writes in RUN are also rejected.
- HC_BUF_LOCK_EN undefined:
  - Descriptor and DSM writes are accepted in any state. buf_valid tracking is unchanged.

## Test plan
- Reset release, then DEASSERT_RST -> afu_reset 1→0 the cycle after the write; STATUS reads 0x1.
- NUM_BUFFERS=2: write addr/size at byte 0x120/0x128 and 0x130/0x138 -> buf_valid=2'b11; readback matches. Write at 0x140 -> err_cnt=1, descriptor 1 unchanged.
- START with only descriptor 0 complete -> state stays IDLE, err_cnt+1. Complete descriptor 1, then START -> afu_running=1 and a single start_pulse.
- HC_BUF_LOCK_EN: in RUN, write 0xDEAD to 0x120 -> buf_addr[63:0] unchanged, err_cnt+1. Without the macro, the value is updated.
- engine_done and STOP in the same cycle -> IDLE next cycle. ASSERT_RST -> buf_valid=0; descriptors retain their values.
- 300 out-of-range writes -> err_cnt saturates at 255. Reads with tids 5, 6, 7 back to back -> responses with the same tids, each 1 cycle later.

Source files
------------

// File: rtl/hc_buffer_regfile.sv
// hc_buffer_regfile: MMIO register file for HardCloud holding the DSM base, control FSM
//   (RST/IDLE/RUN) and NUM_BUFFERS address/size descriptors with bounds checking,
//   descriptor-valid tracking, MMIO readback and a saturating write-error counter.
// Ports: clk/reset (async, active-high); mmio_wr_valid/mmio_rd_valid/mmio_addr (dword)/
//   mmio_tid/mmio_wdata in; mmio_rsp_valid/tid/data out (1-cycle read latency, reads
//   every cycle, no backpressure); engine_done in; dsm_base, buf_addr, buf_size,
//   buf_valid, afu_reset, afu_running, start_pulse, err_cnt out.
// Optional feature: define HC_BUF_LOCK_EN to reject descriptor/DSM writes while in RUN
//   (rejected descriptor writes count as errors).
module hc_buffer_regfile #(
   parameter int          NUM_BUFFERS   = 2,
   parameter logic [15:0] DSM_ADDR      = 16'h110,
   parameter logic [15:0] CONTROL_ADDR  = 16'h118,
   parameter logic [15:0] STATUS_ADDR   = 16'h108,
   parameter logic [15:0] BUF_BASE_ADDR = 16'h120
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mmio_wr_valid,
   input  logic                       mmio_rd_valid,
   input  logic [15:0]                mmio_addr,
   input  logic [8:0]                 mmio_tid,
   input  logic [63:0]                mmio_wdata,
   output logic                       mmio_rsp_valid,
   output logic [8:0]                 mmio_rsp_tid,
   output logic [63:0]                mmio_rsp_data,
   input  logic                       engine_done,
   output logic [63:0]                dsm_base,
   output logic [64*NUM_BUFFERS-1:0]  buf_addr,
   output logic [32*NUM_BUFFERS-1:0]  buf_size,
   output logic [NUM_BUFFERS-1:0]     buf_valid,
   output logic                       afu_reset,
   output logic                       afu_running,
   output logic                       start_pulse,
   output logic [7:0]                 err_cnt
);

   localparam logic [15:0] DSM_DW    = DSM_ADDR >> 2;
   localparam logic [15:0] CTRL_DW   = CONTROL_ADDR >> 2;
   localparam logic [15:0] STATUS_DW = STATUS_ADDR >> 2;
   localparam logic [15:0] BUF_DW    = BUF_BASE_ADDR >> 2;
   localparam logic [15:0] NB16      = 16'(NUM_BUFFERS);

   localparam logic [31:0] CMD_ASSERT_RST   = 32'h0;
   localparam logic [31:0] CMD_DEASSERT_RST = 32'h1;
   localparam logic [31:0] CMD_START        = 32'h3;
   localparam logic [31:0] CMD_STOP         = 32'h7;

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [63:0]            dsm_q, dsm_d;
   logic [63:0]            addr_q [NUM_BUFFERS];
   logic [63:0]            addr_d [NUM_BUFFERS];
   logic [31:0]            size_q [NUM_BUFFERS];
   logic [31:0]            size_d [NUM_BUFFERS];
   logic [NUM_BUFFERS-1:0] addr_seen_q, addr_seen_d;
   logic [NUM_BUFFERS-1:0] size_seen_q, size_seen_d;
   logic [7:0]             err_q, err_d;
   logic                   start_q, start_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [8:0]             rsp_tid_q, rsp_tid_d;
   logic [63:0]            rsp_data_q, rsp_data_d;

   // Address decode shared by the write and read paths.
   logic        in_range;
   logic        buf_region;
   logic        buf_hit;
   logic        is_size;
   logic [15:0] offset;
   logic [15:0] idx;
   logic        wr;
   logic        ctrl_wr;
   logic [31:0] cmd;
   logic        all_valid;
   logic        wr_locked;
   logic        err_inc;

   assign in_range   = (mmio_addr < 16'h0100);
   assign offset     = mmio_addr - BUF_DW;
   assign buf_region = in_range && (mmio_addr >= BUF_DW);
   assign idx        = {2'b00, offset[15:2]};
   // Odd dword offsets and indices past the table are misses, so nothing can alias.
   assign buf_hit    = buf_region && !offset[0] && (idx < NB16);
   assign is_size    = offset[1];
   assign wr         = mmio_wr_valid && in_range;
   assign ctrl_wr    = wr && (mmio_addr == CTRL_DW);
   assign cmd        = mmio_wdata[31:0];
   assign all_valid  = &(addr_seen_q & size_seen_q);

`ifdef HC_BUF_LOCK_EN
   assign wr_locked = (state_q == ST_RUN);
`else
   assign wr_locked = 1'b0;
`endif

   // Register writes, control FSM and error accounting.
   always_comb begin
      state_d     = state_q;
      dsm_d       = dsm_q;
      addr_d      = addr_q;
      size_d      = size_q;
      addr_seen_d = addr_seen_q;
      size_seen_d = size_seen_q;
      err_inc     = 1'b0;

      if (wr && (mmio_addr == DSM_DW) && !wr_locked) begin
         dsm_d = mmio_wdata;
      end

      if (wr && buf_region) begin
         if (!buf_hit || wr_locked) begin
            err_inc = 1'b1;
         end else begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
               if (idx == 16'(i)) begin
                  if (is_size) begin
                     size_d[i]      = mmio_wdata[31:0];
                     size_seen_d[i] = 1'b1;
                  end else begin
                     addr_d[i]      = mmio_wdata;
                     addr_seen_d[i] = 1'b1;
                  end
               end
            end
         end
      end

      if (ctrl_wr && (cmd == CMD_ASSERT_RST)) begin
         state_d     = ST_RST;
         addr_seen_d = '0;
         size_seen_d = '0;
      end else begin
         case (state_q)
            ST_RST: begin
               if (ctrl_wr && (cmd == CMD_DEASSERT_RST)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
               if (ctrl_wr && (cmd == CMD_START)) begin
                  if (all_valid) state_d = ST_RUN;
                  else           err_inc = 1'b1;
               end
            end
            ST_RUN: begin
               // STOP and engine_done agree on the outcome, so they can coincide.
               if (engine_done || (ctrl_wr && (cmd == CMD_STOP))) state_d = ST_IDLE;
            end
            default: state_d = ST_RST;
         endcase
      end

      err_d   = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
      start_d = (state_d == ST_RUN) && (state_q != ST_RUN);
   end

   // Readback uses only _q state, so a read sees values from before any same-cycle write.
   always_comb begin
      rsp_data_d = '0;
      if (in_range) begin
         if (mmio_addr == DSM_DW) begin
            rsp_data_d = dsm_q;
         end else if (mmio_addr == CTRL_DW) begin
            rsp_data_d = {62'b0, state_q};
         end else if (mmio_addr == STATUS_DW) begin
            rsp_data_d = {47'b0, all_valid, err_q, 6'b0, state_q};
         end else if (buf_hit) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
               if (idx == 16'(i)) begin
                  rsp_data_d = is_size ? {32'b0, size_q[i]} : addr_q[i];
               end
            end
         end
      end
      if (!mmio_rd_valid) rsp_data_d = '0;
      rsp_valid_d = mmio_rd_valid;
      rsp_tid_d   = mmio_rd_valid ? mmio_tid : 9'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RST;
         dsm_q       <= '0;
         addr_seen_q <= '0;
         size_seen_q <= '0;
         err_q       <= '0;
         start_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
         for (int i = 0; i < NUM_BUFFERS; i++) begin
            addr_q[i] <= '0;
            size_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         dsm_q       <= dsm_d;
         addr_seen_q <= addr_seen_d;
         size_seen_q <= size_seen_d;
         err_q       <= err_d;
         start_q     <= start_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tid_q   <= rsp_tid_d;
         rsp_data_q  <= rsp_data_d;
         for (int i = 0; i < NUM_BUFFERS; i++) begin
            addr_q[i] <= addr_d[i];
            size_q[i] <= size_d[i];
         end
      end
   end

   always_comb begin
      buf_addr = '0;
      buf_size = '0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
         buf_addr[64*i +: 64] = addr_q[i];
         buf_size[32*i +: 32] = size_q[i];
      end
   end

   assign dsm_base       = dsm_q;
   assign buf_valid      = addr_seen_q & size_seen_q;
   assign afu_reset      = (state_q == ST_RST);
   assign afu_running    = (state_q == ST_RUN);
   assign start_pulse    = start_q;
   assign err_cnt        = err_q;
   assign mmio_rsp_valid = rsp_valid_q;
   assign mmio_rsp_tid   = rsp_tid_q;
   assign mmio_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_hc_buffer_regfile.sv
// tb_hc_buffer_regfile: directed bench for hc_buffer_regfile (NUM_BUFFERS=2).
// Reads push expected {tid, data, due cycle} into a queue; a negedge monitor pops and
// compares each response. Direct outputs are checked #1 after the clock edge.
module tb_hc_buffer_regfile;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         mmio_wr_valid = 1'b0;
   logic         mmio_rd_valid = 1'b0;
   logic [15:0]  mmio_addr = '0;
   logic [8:0]   mmio_tid = '0;
   logic [63:0]  mmio_wdata = '0;
   logic         mmio_rsp_valid;
   logic [8:0]   mmio_rsp_tid;
   logic [63:0]  mmio_rsp_data;
   logic         engine_done = 1'b0;
   logic [63:0]  dsm_base;
   logic [127:0] buf_addr;
   logic [63:0]  buf_size;
   logic [1:0]   buf_valid;
   logic         afu_reset;
   logic         afu_running;
   logic         start_pulse;
   logic [7:0]   err_cnt;

   hc_buffer_regfile #(.NUM_BUFFERS(2)) dut (
      .clk(clk), .reset(reset),
      .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
      .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
      .mmio_rsp_valid(mmio_rsp_valid), .mmio_rsp_tid(mmio_rsp_tid),
      .mmio_rsp_data(mmio_rsp_data), .engine_done(engine_done),
      .dsm_base(dsm_base), .buf_addr(buf_addr), .buf_size(buf_size),
      .buf_valid(buf_valid), .afu_reset(afu_reset), .afu_running(afu_running),
      .start_pulse(start_pulse), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_err = 0;
   logic [63:0] exp_a0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [8:0]  tid;
      logic [63:0] data;
      int          due;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every response must match the oldest outstanding read, one cycle after issue.
   always @(negedge clk) begin
      exp_t e;
      if (mmio_rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got tid %0h with no read outstanding, expected none",
                     mmio_rsp_tid);
         end else begin
            e = exp_q.pop_front();
            chk({e.name, "_tid"}, 128'(mmio_rsp_tid), 128'(e.tid));
            chk({e.name, "_data"}, 128'(mmio_rsp_data), 128'(e.data));
            chk({e.name, "_latency"}, 128'(cyc), 128'(e.due));
         end
      end
   end

   // All tasks start and end at posedge+1.
   task automatic wr(input logic [15:0] baddr, input logic [63:0] d);
      mmio_wr_valid = 1'b1;
      mmio_addr     = baddr >> 2;
      mmio_wdata    = d;
      @(posedge clk); #1;
      mmio_wr_valid = 1'b0;
   endtask

   task automatic rd(input logic [15:0] baddr, input logic [8:0] tid,
                     input logic [63:0] exp, input string name);
      exp_t e;
      e.tid  = tid;
      e.data = exp;
      e.due  = cyc + 1;
      e.name = name;
      exp_q.push_back(e);
      mmio_rd_valid = 1'b1;
      mmio_addr     = baddr >> 2;
      mmio_tid      = tid;
      @(posedge clk); #1;
      mmio_rd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef HC_BUF_LOCK_EN
      exp_a0 = 64'h1111_2222_3333_4444;
`else
      exp_a0 = 64'h0000_0000_0000_DEAD;
`endif
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_afu_reset", 128'(afu_reset), 128'(1));
      chk("rst_afu_running", 128'(afu_running), 128'(0));
      chk("rst_buf_valid", 128'(buf_valid), 128'(0));
      chk("rst_err_cnt", 128'(err_cnt), 128'(0));
      chk("rst_dsm_base", 128'(dsm_base), 128'(0));
      chk("rst_buf_addr", buf_addr, 128'(0));
      chk("rst_start_pulse", 128'(start_pulse), 128'(0));
      chk("rst_rsp_valid", 128'(mmio_rsp_valid), 128'(0));
      reset = 1'b0;
      idle(1);

      // Leave RST
      rd(16'h108, 9'd10, 64'h0, "status_rst");
      wr(16'h118, 64'h1);
      chk("deassert_afu_reset", 128'(afu_reset), 128'(0));
      rd(16'h108, 9'd11, 64'h1, "status_idle");

      // Descriptor 0 only, then premature START
      wr(16'h120, 64'h1111_2222_3333_4444);
      chk("d0_addr_only_valid", 128'(buf_valid), 128'(0));
      wr(16'h128, 64'hFFFF_FFFF_AAAA_0100);
      chk("d0_valid", 128'(buf_valid), 128'(1));
      chk("d0_size_low32", 128'(buf_size[31:0]), 128'(32'hAAAA_0100));
      wr(16'h118, 64'h3);
      exp_err++;
      chk("early_start_err", 128'(err_cnt), 128'(exp_err));
      chk("early_start_not_running", 128'(afu_running), 128'(0));
      rd(16'h118, 9'd12, 64'h1, "ctrl_still_idle");

      // Descriptor 1 and out-of-range/misaligned writes
      wr(16'h130, 64'h5555_6666_7777_8888);
      wr(16'h138, 64'h200);
      chk("both_valid", 128'(buf_valid), 128'(2'b11));
      wr(16'h140, 64'h99);
      exp_err++;
      chk("oob_err", 128'(err_cnt), 128'(exp_err));
      chk("oob_d1_addr_kept", 128'(buf_addr[127:64]), 128'(64'h5555_6666_7777_8888));
      chk("oob_d1_size_kept", 128'(buf_size[63:32]), 128'(32'h200));
      wr(16'h124, 64'h77);
      exp_err++;
      chk("odd_offset_err", 128'(err_cnt), 128'(exp_err));
      chk("odd_offset_d0_kept", 128'(buf_addr[63:0]), 128'(64'h1111_2222_3333_4444));
      wr(16'h400, 64'h55);
      chk("above_decode_no_err", 128'(err_cnt), 128'(exp_err));
      wr(16'h110, 64'hABCD_0000);
      chk("dsm_write", 128'(dsm_base), 128'(64'hABCD_0000));

      // Readback
      rd(16'h120, 9'd13, 64'h1111_2222_3333_4444, "rb_d0_addr");
      rd(16'h128, 9'd14, 64'h0000_0000_AAAA_0100, "rb_d0_size");
      rd(16'h138, 9'd15, 64'h200, "rb_d1_size");
      rd(16'h110, 9'd16, 64'hABCD_0000, "rb_dsm");
      rd(16'h100, 9'd17, 64'h0, "rb_unmapped");
      rd(16'h108, 9'd18, 64'h0000_0000_0001_0301, "rb_status");

      // START succeeds, single pulse
      wr(16'h118, 64'h3);
      chk("start_running", 128'(afu_running), 128'(1));
      chk("start_pulse_first", 128'(start_pulse), 128'(1));
      idle(1);
      chk("start_pulse_second", 128'(start_pulse), 128'(0));
      chk("still_running", 128'(afu_running), 128'(1));

      // Descriptor write while running
      wr(16'h120, 64'hDEAD);
`ifdef HC_BUF_LOCK_EN
      exp_err++;
`endif
      chk("run_wr_d0_addr", 128'(buf_addr[63:0]), 128'(exp_a0));
      chk("run_wr_err", 128'(err_cnt), 128'(exp_err));

      // engine_done coinciding with STOP
      engine_done = 1'b1;
      wr(16'h118, 64'h7);
      engine_done = 1'b0;
      chk("done_stop_idle", 128'(afu_running), 128'(0));
      rd(16'h118, 9'd19, 64'h1, "ctrl_after_done_stop");

      // engine_done alone
      wr(16'h118, 64'h3);
      chk("restart_pulse", 128'(start_pulse), 128'(1));
      engine_done = 1'b1;
      idle(1);
      engine_done = 1'b0;
      chk("done_idle", 128'(afu_running), 128'(0));

      // ASSERT_RST keeps descriptors
      wr(16'h118, 64'h0);
      chk("assert_rst_afu_reset", 128'(afu_reset), 128'(1));
      chk("assert_rst_buf_valid", 128'(buf_valid), 128'(0));
      chk("assert_rst_d0_kept", 128'(buf_addr[63:0]), 128'(exp_a0));
      chk("assert_rst_d1_size_kept", 128'(buf_size[63:32]), 128'(32'h200));

      // Saturation
      for (int i = 0; i < 300; i++) wr(16'h140, 64'h1);
      chk("err_saturated", 128'(err_cnt), 128'(8'hFF));

      // Back-to-back reads
      rd(16'h108, 9'd5, 64'h0000_0000_0000_FF00, "b2b_status");
      rd(16'h130, 9'd6, 64'h5555_6666_7777_8888, "b2b_d1_addr");
      rd(16'h118, 9'd7, 64'h0, "b2b_ctrl");
      idle(2);

      // Back to RUN, then asynchronous reset with a response in flight
      wr(16'h118, 64'h1);
      wr(16'h120, 64'h1);
      wr(16'h128, 64'h2);
      wr(16'h130, 64'h3);
      wr(16'h138, 64'h4);
      wr(16'h118, 64'h3);
      chk("rerun_running", 128'(afu_running), 128'(1));
      mmio_rd_valid = 1'b1;
      mmio_addr     = 16'h108 >> 2;
      mmio_tid      = 9'd9;
      @(posedge clk); #1;
      mmio_rd_valid = 1'b0;
      chk("inflight_rsp_valid", 128'(mmio_rsp_valid), 128'(1));
      reset = 1'b1;
      #1;
      chk("async_rsp_dropped", 128'(mmio_rsp_valid), 128'(0));
      chk("async_afu_reset", 128'(afu_reset), 128'(1));
      chk("async_afu_running", 128'(afu_running), 128'(0));
      chk("async_err_cnt", 128'(err_cnt), 128'(0));
      chk("async_buf_valid", 128'(buf_valid), 128'(0));
      chk("async_buf_addr", buf_addr, 128'(0));
      chk("async_dsm", 128'(dsm_base), 128'(0));
      idle(2);
      reset = 1'b0;
      idle(3);

      chk("rsp_queue_empty", 128'(exp_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
